nibble_compare_seq: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands with a single shared 4-bit magnitude-compare stage. It walks the nibbles MSB-first, one nibble per clock. It stops at the first differing nibble when EARLY_EXIT=1. Operands are accepted through a valid/ready handshake, and the registered A>B / A=B / A<B result is returned through a second valid/ready handshake. It sits between operand producers and the consumers of the comparison result.

---
 rtl/nibble_compare_seq.sv | 167 ++++++++++++++++
 tb/tb_nibble_compare_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_compare_seq.sv
// -----------------------------------------------------------------------------
// nibble_compare_seq
//
// Compares two WIDTH-bit unsigned operands using one shared 4-bit magnitude
// compare. Nibbles are examined MSB-first, one per clock. When EARLY_EXIT=1 the
// scan stops at the first differing nibble. When EARLY_EXIT=0 all N nibbles are
// always scanned, which gives a constant latency.
//
// Ports
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b sampled on acceptance)
//   a, b                 : unsigned operands
//   out_valid / out_ready: result handshake
//   gt, eq, lt           : registered one-hot result; all zero when !out_valid
//   steps                : nibble compares performed for the current result
//   busy                 : high while comparing
//   dbg_state            : current FSM state (0=IDLE, 1=CMP, 2=DONE)
//
// Handshake rule: a transfer happens on a rising edge where valid && ready.
// The producer holds valid (and data) until ready. The block holds its result
// stable while out_valid && !out_ready. in_valid outside IDLE is ignored and is
// not queued.
// -----------------------------------------------------------------------------
module nibble_compare_seq #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          gt,
    output logic                          eq,
    output logic                          lt,
    output logic [$clog2(WIDTH/4):0]      steps,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [SW-1:0]    r_steps;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    // Sticky record of the first difference. It is used only for the full scan.
    logic             r_found;
    logic             r_fgt;
    logic             r_flt;

    logic [WIDTH-1:0] w_sh_a;
    logic [WIDTH-1:0] w_sh_b;
    logic [3:0]       w_na;
    logic [3:0]       w_nb;
    logic             w_ngt;
    logic             w_nlt;
    logic             w_fgt;
    logic             w_flt;
    logic             w_fnd;

    // Select nibble idx by shifting it down to bit 0.
    assign w_sh_a = r_a >> {r_idx, 2'b00};
    assign w_sh_b = r_b >> {r_idx, 2'b00};
    assign w_na   = w_sh_a[3:0];
    assign w_nb   = w_sh_b[3:0];
    assign w_ngt  = (w_na > w_nb);
    assign w_nlt  = (w_na < w_nb);

    // The first difference wins. Later nibbles never override it.
    assign w_fgt  = r_found ? r_fgt : w_ngt;
    assign w_flt  = r_found ? r_flt : w_nlt;
    assign w_fnd  = r_found | w_ngt | w_nlt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_CMP);
    assign gt        = r_gt;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign steps     = r_steps;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_steps <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_found <= 1'b0;
            r_fgt   <= 1'b0;
            r_flt   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= IW'(N - 1);
                        r_steps <= '0;
                        r_found <= 1'b0;
                        r_fgt   <= 1'b0;
                        r_flt   <= 1'b0;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_steps <= r_steps + 1'b1;
                    if (EARLY_EXIT != 0) begin
                        if (w_ngt || w_nlt) begin
                            r_gt    <= w_ngt;
                            r_lt    <= w_nlt;
                            r_eq    <= 1'b0;
                            r_state <= S_DONE;
                        end else if (r_idx == '0) begin
                            r_eq    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end else begin
                        if (r_idx == '0) begin
                            r_gt    <= w_fgt;
                            r_lt    <= w_flt;
                            r_eq    <= ~w_fnd;
                            r_state <= S_DONE;
                        end else begin
                            r_found <= w_fnd;
                            r_fgt   <= w_fgt;
                            r_flt   <= w_flt;
                            r_idx   <= r_idx - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_gt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_compare_seq.sv
// Bench for nibble_compare_seq: instance 0 uses EARLY_EXIT=1, instance 1 uses
// EARLY_EXIT=0. Expected results come from plain unsigned arithmetic. Expected
// step counts come from a first-differing-nibble search.
module tb_nibble_compare_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [15:0] a_s         [2];
    logic [15:0] b_s         [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic        gt_s        [2];
    logic        eq_s        [2];
    logic        lt_s        [2];
    logic [2:0]  steps_s     [2];
    logic        busy_s      [2];
    logic [1:0]  dbg_s       [2];

    int n_checks = 0;
    int n_pass   = 0;

    nibble_compare_seq #(.WIDTH(16), .EARLY_EXIT(1)) u_ee1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .gt(gt_s[0]), .eq(eq_s[0]), .lt(lt_s[0]),
        .steps(steps_s[0]), .busy(busy_s[0]), .dbg_state(dbg_s[0])
    );

    nibble_compare_seq #(.WIDTH(16), .EARLY_EXIT(0)) u_ee0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .gt(gt_s[1]), .eq(eq_s[1]), .lt(lt_s[1]),
        .steps(steps_s[1]), .busy(busy_s[1]), .dbg_state(dbg_s[1])
    );

    // Clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: compares per nibble from the MSB. A full scan always takes 4 steps.
    function automatic int exp_steps(input bit early, input logic [15:0] av, input logic [15:0] bv);
        if (!early) return 4;
        for (int k = 0; k < 4; k++) begin
            if (av[15-4*k -: 4] != bv[15-4*k -: 4]) return k + 1;
        end
        return 4;
    endfunction

    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv, input int hold);
        int lat;
        int es;
        logic eg, ee, el;
        es = exp_steps(sel == 0, av, bv);
        eg = (av > bv);
        ee = (av == bv);
        el = (av < bv);
        @(negedge clk);
        a_s[sel] = av;
        b_s[sel] = bv;
        in_valid_s[sel] = 1'b1;
        out_ready_s[sel] = 1'b0;
        check("in_ready_idle", in_ready_s[sel], 1);
        @(posedge clk);
        #1;
        in_valid_s[sel] = 1'b0;
        // Operand changes after acceptance must not affect the result.
        a_s[sel] = 16'hFFFF;
        b_s[sel] = 16'($urandom);
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid_s[sel]) break;
            check("busy_in_cmp", busy_s[sel], 1);
            check("in_ready_cmp", in_ready_s[sel], 0);
            check("flags_zero_cmp", {gt_s[sel], eq_s[sel], lt_s[sel]}, 0);
            lat++;
            if (lat > 20) break;
        end
        check("latency", lat, es);
        check("gt", gt_s[sel], eg);
        check("eq", eq_s[sel], ee);
        check("lt", lt_s[sel], el);
        check("steps", steps_s[sel], es);
        for (int h = 0; h < hold; h++) begin
            in_valid_s[sel] = 1'b1;
            a_s[sel] = 16'($urandom);
            b_s[sel] = 16'($urandom);
            @(negedge clk);
            check("bp_out_valid", out_valid_s[sel], 1);
            check("bp_result", {gt_s[sel], eq_s[sel], lt_s[sel]}, {eg, ee, el});
            check("bp_steps", steps_s[sel], es);
            check("bp_in_ready", in_ready_s[sel], 0);
        end
        in_valid_s[sel] = 1'b0;
        out_ready_s[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[sel] = 1'b0;
        @(negedge clk);
        check("post_out_valid", out_valid_s[sel], 0);
        check("post_flags", {gt_s[sel], eq_s[sel], lt_s[sel]}, 0);
        check("post_in_ready", in_ready_s[sel], 1);
        check("post_steps_held", steps_s[sel], es);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int sel;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_s[i] = 1'b0;
            out_ready_s[i] = 1'b0;
            a_s[i] = '0;
            b_s[i] = '0;
        end
        #2;
        // An input pulse during reset must be ignored.
        in_valid_s[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_out_valid", out_valid_s[i], 0);
            check("rst_flags", {gt_s[i], eq_s[i], lt_s[i]}, 0);
            check("rst_steps", steps_s[i], 0);
            check("rst_busy", busy_s[i], 0);
            check("rst_in_ready", in_ready_s[i], 1);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_ignores_in", busy_s[0], 0);
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(0, 16'h1234, 16'h1234, 0);
        run_op(0, 16'h8000, 16'h7FFF, 0);
        run_op(0, 16'h12A4, 16'h12B4, 0);
        run_op(1, 16'h8000, 16'h7FFF, 0);
        run_op(1, 16'h0001, 16'h0002, 0);
        run_op(0, 16'h00F0, 16'h00E0, 6);
        run_op(0, 16'h5555, 16'h5555, 0);
        run_op(1, 16'h5555, 16'h5555, 2);

        // Reset during an in-flight full-scan comparison
        @(negedge clk);
        a_s[1] = 16'h1000;
        b_s[1] = 16'h2000;
        in_valid_s[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_s[1], 0);
        check("midrst_flags", {gt_s[1], eq_s[1], lt_s[1]}, 0);
        check("midrst_steps", steps_s[1], 0);
        check("midrst_busy", busy_s[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready_s[1], 1);
        run_op(1, 16'h2000, 16'h1000, 0);

        // Randomized operations. B often shares leading nibbles with A.
        for (int t = 0; t < 24; t++) begin
            sel = int'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = ra;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) rb[4*k +: 4] = 4'($urandom);
            end
            if ($urandom_range(0, 4) == 0) rb = 16'($urandom);
            run_op(sel, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
